// File: rtl/sw_pkg.sv
// sw_pkg: shared switch-conditioning constants and counter sizing helper
package sw_pkg;
    localparam int SW_WIDTH              = 4;
    localparam int SW_DEBOUNCE_5MHZ_20MS = 99_999;
    localparam int SW_DEBOUNCE_SIM       = 3;
    // $clog2(1) is 0, so a zero-cycle debounce still gets a 1-bit counter
    function automatic int sw_cnt_w(input int cnt);
        return (cnt > 0) ? $clog2(cnt + 1) : 1;
    endfunction
endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: one-bit synchronizer + debounce counter with rise/fall pulses
// Ports: clk_in, rst (sync, active-high), sw (raw pin), sw_clean (debounced level),
//        sw_rise/sw_fall (registered one-cycle pulses), rise_nxt/fall_nxt (next-state pulses)
module sw_debounce_bit
    import sw_pkg::*;
#(
    parameter int DEBOUNCE_CNT = SW_DEBOUNCE_5MHZ_20MS
) (
    input  logic clk_in,
    input  logic rst,
    input  logic sw,
    output logic sw_clean,
    output logic sw_rise,
    output logic sw_fall,
    output logic rise_nxt,
    output logic fall_nxt
);
    localparam int CW = sw_cnt_w(DEBOUNCE_CNT);
    logic s1, s2, done;
    logic [CW-1:0] cnt;
    assign done     = (s2 != sw_clean) && (cnt == CW'(DEBOUNCE_CNT));
    assign rise_nxt = done && s2;
    assign fall_nxt = done && !s2;
    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            cnt      <= '0;
            sw_clean <= 1'b0;
            sw_rise  <= 1'b0;
            sw_fall  <= 1'b0;
        end else begin
            s1       <= sw;
            s2       <= s1;
            // any sample matching the clean level restarts qualification
            cnt      <= (s2 == sw_clean || done) ? '0 : cnt + 1'b1;
            sw_clean <= done ? s2 : sw_clean;
            sw_rise  <= rise_nxt;
            sw_fall  <= fall_nxt;
        end
    end
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: per-bit switch synchronizer/debouncer with rise, fall and change events
// Ports: clk_in, rst (sync, active-high), sw[WIDTH] (raw pins), sw_clean[WIDTH],
//        sw_rise[WIDTH], sw_fall[WIDTH], sw_changed (any clean bit changed),
//        sw_toggle[WIDTH] (only when SW_DEBOUNCE_TOGGLE_EN is defined: push-on/push-off)
module sw_debounce
    import sw_pkg::*;
#(
    parameter int WIDTH        = SW_WIDTH,
    parameter int DEBOUNCE_CNT = SW_DEBOUNCE_5MHZ_20MS
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
`ifdef SW_DEBOUNCE_TOGGLE_EN
    output logic             sw_changed,
    output logic [WIDTH-1:0] sw_toggle
`else
    output logic             sw_changed
`endif
);
    logic [WIDTH-1:0] rise_nxt, fall_nxt;
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            sw_debounce_bit #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_bit (
                .clk_in   (clk_in),
                .rst      (rst),
                .sw       (sw[i]),
                .sw_clean (sw_clean[i]),
                .sw_rise  (sw_rise[i]),
                .sw_fall  (sw_fall[i]),
                .rise_nxt (rise_nxt[i]),
                .fall_nxt (fall_nxt[i])
            );
        end
    endgenerate
    // built from next-state pulses so it lands in the same cycle as rise/fall
    always_ff @(posedge clk_in) begin
        sw_changed <= rst ? 1'b0 : |(rise_nxt | fall_nxt);
    end
`ifdef SW_DEBOUNCE_TOGGLE_EN
    always_ff @(posedge clk_in) begin
        sw_toggle <= rst ? '0 : sw_toggle ^ rise_nxt;
    end
`endif
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: table-driven, directed and randomized checks of sw_debounce
module tb_sw_debounce;
    import sw_pkg::*;
    localparam int W = SW_WIDTH;
    localparam int D = SW_DEBOUNCE_SIM;

    logic         clk_in = 1'b0;
    logic         rst    = 1'b1;
    logic [W-1:0] sw     = '0;
    logic [W-1:0] sw_clean, sw_rise, sw_fall;
    logic         sw_changed;
`ifdef SW_DEBOUNCE_TOGGLE_EN
    logic [W-1:0] sw_toggle;
`endif

    sw_debounce #(.WIDTH(W), .DEBOUNCE_CNT(D)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .sw         (sw),
        .sw_clean   (sw_clean),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
`ifdef SW_DEBOUNCE_TOGGLE_EN
        .sw_changed (sw_changed),
        .sw_toggle  (sw_toggle)
`else
        .sw_changed (sw_changed)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: a bit's clean level flips once its synchronized value has
    // disagreed with it on D+1 consecutive edges (window of recent samples)
    logic [W-1:0] m_s1 = '0, m_s2 = '0, m_clean = '0, m_rise = '0, m_fall = '0, m_tog = '0;
    logic         m_chg = 1'b0;
    logic [D:0]   win [W];
    int           fill[W];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [W-1:0] s, input logic r);
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0; m_tog = '0; m_chg = 1'b0;
            for (int b = 0; b < W; b++) begin
                win[b]  = '0;
                fill[b] = 0;
            end
        end else begin
            for (int b = 0; b < W; b++) begin
                m_rise[b] = 1'b0;
                m_fall[b] = 1'b0;
                win[b]    = {win[b][D-1:0], m_s2[b]};
                fill[b]   = (fill[b] < D + 1) ? fill[b] + 1 : D + 1;
                if (fill[b] == D + 1 && win[b] == {(D+1){~m_clean[b]}}) begin
                    m_clean[b] = ~m_clean[b];
                    m_rise[b]  = m_clean[b];
                    m_fall[b]  = ~m_clean[b];
                    fill[b]    = 0;
                end
            end
            m_chg = |(m_rise | m_fall);
            m_tog = m_tog ^ m_rise;
            m_s2  = m_s1;
            m_s1  = s;
        end
    endtask

    // drive one cycle, advance the model on the edge, compare on the falling edge
    task automatic step(input logic [W-1:0] s, input logic r);
        sw  = s;
        rst = r;
        @(posedge clk_in);
        model_edge(s, r);
        @(negedge clk_in);
        chk("m_clean", sw_clean, m_clean);
        chk("m_rise", sw_rise, m_rise);
        chk("m_fall", sw_fall, m_fall);
        chk("m_changed", sw_changed, m_chg);
`ifdef SW_DEBOUNCE_TOGGLE_EN
        chk("m_toggle", sw_toggle, m_tog);
`endif
    endtask

    task automatic reset_dut();
        step('0, 1'b1);
        step('0, 1'b0);
        step('0, 1'b0);
    endtask

    typedef struct {
        logic [W-1:0] sw;
        logic         rst;
        logic [W-1:0] clean;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int n, input logic [W-1:0] s, input logic r, input logic [W-1:0] c,
                       input logic [W-1:0] ri, input logic [W-1:0] f, input logic ch);
        for (int k = 0; k < n; k++) tbl.push_back('{s, r, c, ri, f, ch});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lat, bounce_pulses;
        logic [W-1:0] acc, v;
        // reset, then clean step on sw[0] (rise at edge 5), release, reset mid-count on sw[2]
        add(1, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(2, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(5, 4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(1, 4'b0001, 1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1);
        add(2, 4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        add(5, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        add(1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b1);
        add(1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(3, 4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(1, 4'b0100, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(5, 4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(1, 4'b0100, 1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b1);
        add(1, 4'b0100, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0);

        @(negedge clk_in);
        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].sw, tbl[k].rst);
            chk($sformatf("tbl%0d_clean", k), sw_clean, tbl[k].clean);
            chk($sformatf("tbl%0d_rise", k), sw_rise, tbl[k].rise);
            chk($sformatf("tbl%0d_fall", k), sw_fall, tbl[k].fall);
            chk($sformatf("tbl%0d_chg", k), sw_changed, tbl[k].chg);
        end

        // bounce on sw[1] every 2 cycles, then settle high
        reset_dut();
        bounce_pulses = 0;
        for (int k = 0; k < 20; k++) begin
            v    = '0;
            v[1] = ((k / 2) % 2 == 0);
            step(v, 1'b0);
            if (sw_changed || sw_rise != 0 || sw_fall != 0) bounce_pulses++;
        end
        chk("bounce_pulses", bounce_pulses, 0);
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            step(4'b0010, 1'b0);
            if (lat < 0 && sw_clean[1]) lat = k;
        end
        chk("bounce_latency", lat, 5);

        // simultaneous qualification of two bits
        reset_dut();
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step(4'b1100, 1'b0);
            if (sw_changed) begin
                n++;
                chk("sim_rise", sw_rise, 4'b1100);
                chk("sim_clean", sw_clean, 4'b1100);
            end
        end
        chk("sim_rise_events", n, 1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step(4'b0000, 1'b0);
            if (sw_changed) begin
                n++;
                chk("sim_fall", sw_fall, 4'b1100);
            end
        end
        chk("sim_fall_events", n, 1);

        // 3-cycle glitch must not qualify
        reset_dut();
        acc = '0;
        for (int k = 0; k < 12; k++) begin
            step((k < 3) ? 4'b0001 : 4'b0000, 1'b0);
            acc = acc | sw_clean | sw_rise | sw_fall | {3'b000, sw_changed};
        end
        chk("glitch_outputs", acc, 4'b0000);

`ifdef SW_DEBOUNCE_TOGGLE_EN
        begin
            logic [2:0] seq;
            reset_dut();
            seq = '0;
            for (int p = 0; p < 3; p++) begin
                for (int k = 0; k < 8; k++) step(4'b1000, 1'b0);
                seq[p] = sw_toggle[3];
                for (int k = 0; k < 8; k++) step(4'b0000, 1'b0);
                chk("toggle_hold", sw_toggle[3], seq[p]);
            end
            chk("toggle_seq", seq, 3'b101);
        end
`endif

        // randomized runs of held values with occasional reset
        reset_dut();
        for (int r = 0; r < 300; r++) begin
            logic rr;
            int   hold;
            v    = W'($urandom_range(0, (1 << W) - 1));
            hold = $urandom_range(1, 7);
            rr   = ($urandom_range(0, 49) == 0);
            for (int h = 0; h < hold; h++) step(v, rr && h == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
